// File: rtl/sky130_ef_ip__sar_pkg.sv
// SAR controller shared types and helpers.
// Trial-code function is reused by any SAR variant.
package sky130_ef_ip__sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    DONE
  } sar_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_SYNC_STAGES   = 2;

  // keep bits above idx, set bit idx, clear everything below
  function automatic int unsigned sar_trial(
    input int unsigned res,
    input int unsigned idx
  );
    int unsigned b;
    b = 32'd1 << idx;
    return (res & ~((b - 32'd1) | b)) | b;
  endfunction

endpackage

// File: rtl/sky130_ef_ip__sync_ff.sv
// Generic N-stage synchronizer for asynchronous analog outputs.
// All stages clear on reset.
module sky130_ef_ip__sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sky130_ef_ip__sar_ctrl.sv
// Successive-approximation controller around the 3.3V comparator.
// MSB-first search, result handed off on valid/ready.
module sky130_ef_ip__sar_ctrl
  import sky130_ef_ip__sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int T    = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CMAX = (SAMPLE_CYCLES > T) ? SAMPLE_CYCLES : T;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cmp_s;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] first_trial;
  logic [WIDTH-1:0] next_trial;

  sky130_ef_ip__sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cmp_in),
    .q    (cmp_s)
  );

  // current trial with bit idx replaced by the decision
  always_comb begin
    res        = dac_q;
    res[idx_q] = cmp_s;
  end

  assign first_trial = WIDTH'(sar_trial(32'd0, 32'(WIDTH - 1)));
  assign next_trial  = WIDTH'(sar_trial(32'(res), 32'(idx_q - IW'(1))));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    dac_d    = dac_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = SAMPLE;
          cnt_d    = '0;
          sample_d = 1'b1;
          busy_d   = 1'b1;
          dac_d    = '0;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d  = IDLE;
          cnt_d    = '0;
          sample_d = 1'b0;
          busy_d   = 1'b0;
          dac_d    = '0;
        end else if (cnt_q == CW'(SAMPLE_CYCLES - 1)) begin
          state_d  = TRIAL;
          cnt_d    = '0;
          sample_d = 1'b0;
          idx_d    = IW'(WIDTH - 1);
          dac_d    = first_trial;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRIAL: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          dac_d   = '0;
        end else if (cnt_q == CW'(T - 1)) begin
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = DONE;
            data_d  = res;
            dac_d   = res;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q - IW'(1);
            dac_d = next_trial;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (abort || data_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dac_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      dac_q    <= dac_d;
      data_q   <= data_d;
    end
  end

  assign sample     = sample_q;
  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign dac_code   = dac_q;
  assign data       = data_q;

endmodule

// File: tb/tb_sky130_ef_ip__sar_ctrl.sv
// Self-checking bench: comparator model drives cmp_in from an
// analog level (in tenths) compared against dac_code.
module tb_sky130_ef_ip__sar_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start0, abort0, ready0;
  logic       sample0, busy0, valid0, cmp0;
  logic [7:0] dac0, data0;
  int         vin0;

  logic       start1, abort1, ready1, glitch1;
  logic       sample1, busy1, valid1, cmp1;
  logic [3:0] dac1, data1;
  int         vin1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign cmp0 = (vin0 > 10 * int'(dac0));
  assign cmp1 = (vin1 > 10 * int'(dac1)) ^ glitch1;

  sky130_ef_ip__sar_ctrl u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .abort     (abort0),
    .cmp_in    (cmp0),
    .sample    (sample0),
    .dac_code  (dac0),
    .busy      (busy0),
    .data      (data0),
    .data_valid(valid0),
    .data_ready(ready0)
  );

  sky130_ef_ip__sar_ctrl #(
    .WIDTH        (4),
    .SAMPLE_CYCLES(4),
    .SETTLE_CYCLES(1),
    .SYNC_STAGES  (3)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .abort     (abort1),
    .cmp_in    (cmp1),
    .sample    (sample1),
    .dac_code  (dac1),
    .busy      (busy1),
    .data      (data1),
    .data_valid(valid1),
    .data_ready(ready1)
  );

  typedef struct {
    int vx;
    int expd;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ideal SAR: largest code strictly below the input, clamped
  function automatic int model(input int vx, input int w);
    int c;
    c = (vx + 9) / 10 - 1;
    if (c < 0) c = 0;
    if (c > (1 << w) - 1) c = (1 << w) - 1;
    return c;
  endfunction

  // k-th trial: result bits above b, bit b set, rest clear
  function automatic int trial(input int e, input int k, input int w);
    int b;
    b = w - 1 - k;
    return ((e >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  task automatic accept0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic conv0(input int vx, input int expd, input string tag);
    int cyc, ns, k, bad, last;
    vin0 = vx;
    accept0();
    cyc = 0; ns = 0; k = 0; bad = 0; last = 0;
    while (cyc < 100) begin
      if (sample0) ns++;
      if (!valid0 && int'(dac0) != last) begin
        if (k >= 8 || int'(dac0) != trial(expd, k, 8)) bad++;
        k++;
        last = int'(dac0);
      end
      if (valid0) break;
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_latency"}, cyc, 36);
    chk({tag, "_sample_cycles"}, ns, 4);
    chk({tag, "_trial_count"}, k, 8);
    chk({tag, "_trial_bad"}, bad, 0);
    chk({tag, "_data"}, int'(data0), expd);
    chk({tag, "_busy_low"}, int'(busy0), 0);
  endtask

  task automatic conv1(input int vx, input int expd,
                       input bit glitch, input string tag);
    int cyc;
    vin1 = vx;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      if (valid1) break;
      // corrupt every capture edge except the one each decision uses
      glitch1 = glitch && !((cyc + 1) >= 5 && ((cyc + 1 - 5) % 4) == 0);
      @(posedge clk);
      #1 cyc++;
    end
    glitch1 = 1'b0;
    chk({tag, "_latency"}, cyc, 20);
    chk({tag, "_data"}, int'(data1), expd);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 0; abort0 = 0; ready0 = 1; vin0 = 0;
    start1 = 0; abort1 = 0; ready1 = 1; vin1 = 0; glitch1 = 0;

    tbl[0] = '{1655, 8'hA5};
    tbl[1] = '{2, 8'h00};
    tbl[2] = '{2557, 8'hFF};
    tbl[3] = '{425, 8'h2A};
    tbl[4] = '{2005, 8'hC8};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", int'(sample0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_dac", int'(dac0), 0);
    chk("rst_data", int'(data0), 0);
    chk("rst_w4_busy", int'(busy1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_model", i), model(tbl[i].vx, 8), tbl[i].expd);
      conv0(tbl[i].vx, tbl[i].expd, $sformatf("tbl%0d", i));
      repeat (2) @(posedge clk);
      #1;
    end

    // backpressure, start during DONE, start on transfer edge
    ready0 = 1'b0;
    conv0(1000, 99, "bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 5) start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      chk($sformatf("bp_hold%0d", c),
          int'({valid0, data0}), 256 + 99);
    end
    chk("bp_busy_done", int'(busy0), 0);
    @(negedge clk);
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("bp_xfer_valid", int'(valid0), 0);
    chk("bp_xfer_data", int'(data0), 99);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_idle_busy", int'(busy0), 0);
    chk("bp_idle_sample", int'(sample0), 0);

    // abort at cycle 15 of a conversion
    vin0 = 1655;
    accept0();
    repeat (14) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk);
    #1 abort0 = 1'b0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_sample", int'(sample0), 0);
    chk("abort_dac", int'(dac0), 0);
    chk("abort_valid", int'(valid0), 0);
    chk("abort_data", int'(data0), 99);
    conv0(425, 8'h2A, "post_abort");
    repeat (2) @(posedge clk);

    // asynchronous reset mid-TRIAL, off the clock edge
    vin0 = 1655;
    accept0();
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_sample", int'(sample0), 0);
    chk("mrst_busy", int'(busy0), 0);
    chk("mrst_dac", int'(dac0), 0);
    chk("mrst_valid", int'(valid0), 0);
    chk("mrst_data", int'(data0), 0);
    rst_n = 1'b1;
    conv0(2005, 8'hC8, "post_rst");
    repeat (2) @(posedge clk);

    for (int r = 0; r < 6; r++) begin
      int vx;
      vx = int'($urandom_range(0, 2600));
      conv0(vx, model(vx, 8), $sformatf("rnd%0d", r));
      repeat (1) @(posedge clk);
    end

    conv1(95, 9, 1'b0, "w4");
    repeat (2) @(posedge clk);
    conv1(95, 9, 1'b1, "w4_glitch");
    repeat (2) @(posedge clk);
    conv1(42, 4, 1'b1, "w4_glitch_b");
    repeat (2) @(posedge clk);
    for (int r = 0; r < 3; r++) begin
      int vx;
      vx = int'($urandom_range(0, 170));
      conv1(vx, model(vx, 4), 1'b1, $sformatf("w4_rnd%0d", r));
      repeat (2) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
